// File: rtl/shift_serial_deserializer.sv
// shift_serial_deserializer: assembles framed serial bits (start, data,
// optional parity, stop) into parallel words for the 8-bit shift register
// stage, flags framing errors and keeps a saturating error count.
// Optional even-parity bit enabled by defining SHIFT_DESER_PARITY_EN.
module shift_serial_deserializer #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter bit          LSB_FIRST     = 1'b1,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bitIn,
    input  logic                     bitValid,
    output logic [DATA_WIDTH-1:0]    wordOut,
    output logic                     wordValid,
    output logic                     frameError,
    output logic                     busy,
    output logic [ERR_CNT_WIDTH-1:0] errorCount
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]         LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = '1;

`ifdef SHIFT_DESER_PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0]    word_q, word_d;
    logic                     word_valid_q, word_valid_d;
    logic                     frame_error_q, frame_error_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
`ifdef SHIFT_DESER_PARITY_EN
    logic                     par_q, par_d;
    logic                     par_err_q, par_err_d;
`endif

    // Next-state and next-output decode; nothing moves on stall cycles
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        word_d        = word_q;
        word_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        err_cnt_d     = err_cnt_q;
`ifdef SHIFT_DESER_PARITY_EN
        par_d         = par_q;
        par_err_d     = par_err_q;
`endif
        if (bitValid) begin
            case (state_q)
                IDLE: begin
                    if (!bitIn) begin
                        state_d = DATA;
                        cnt_d   = '0;
`ifdef SHIFT_DESER_PARITY_EN
                        par_d     = 1'b0;
                        par_err_d = 1'b0;
`endif
                    end
                end
                DATA: begin
                    if (LSB_FIRST)
                        shreg_d = {bitIn, shreg_q[DATA_WIDTH-1:1]};
                    else
                        shreg_d = {shreg_q[DATA_WIDTH-2:0], bitIn};
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef SHIFT_DESER_PARITY_EN
                    par_d = par_q ^ bitIn;
                    if (cnt_q == LAST_BIT)
                        state_d = PARITY;
`else
                    if (cnt_q == LAST_BIT)
                        state_d = STOP;
`endif
                end
`ifdef SHIFT_DESER_PARITY_EN
                PARITY: begin
                    // Even parity: data XOR parity bit must be zero
                    par_err_d = par_q ^ bitIn;
                    state_d   = STOP;
                end
`endif
                STOP: begin
                    // A 0 stop bit is consumed here, never taken as a new start
                    state_d = IDLE;
`ifdef SHIFT_DESER_PARITY_EN
                    if (bitIn && !par_err_q) begin
`else
                    if (bitIn) begin
`endif
                        word_d       = shreg_q;
                        word_valid_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                        if (err_cnt_q != ERR_MAX)
                            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            word_q        <= '0;
            word_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            err_cnt_q     <= '0;
`ifdef SHIFT_DESER_PARITY_EN
            par_q         <= 1'b0;
            par_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            word_q        <= word_d;
            word_valid_q  <= word_valid_d;
            frame_error_q <= frame_error_d;
            err_cnt_q     <= err_cnt_d;
`ifdef SHIFT_DESER_PARITY_EN
            par_q         <= par_d;
            par_err_q     <= par_err_d;
`endif
        end
    end

    assign wordOut    = word_q;
    assign wordValid  = word_valid_q;
    assign frameError = frame_error_q;
    assign errorCount = err_cnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_shift_serial_deserializer.sv
// Directed self-checking bench for shift_serial_deserializer.
// Honours SHIFT_DESER_PARITY_EN when defined for the build.
module tb_shift_serial_deserializer;

    localparam int unsigned DW = 8;
    localparam int unsigned EW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          bitIn;
    logic          bitValid;
    logic [DW-1:0] wordOut;
    logic          wordValid;
    logic          frameError;
    logic          busy;
    logic [EW-1:0] errorCount;

    int passed = 0;
    int total  = 0;
    int wv_pulses = 0;
    int fe_pulses = 0;
    logic both_seen = 1'b0;
    int wv0, fe0, base;
`ifdef SHIFT_DESER_PARITY_EN
    logic par_flip = 1'b0;
`endif

    shift_serial_deserializer #(
        .DATA_WIDTH   (DW),
        .LSB_FIRST    (1'b1),
        .ERR_CNT_WIDTH(EW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bitIn     (bitIn),
        .bitValid  (bitValid),
        .wordOut   (wordOut),
        .wordValid (wordValid),
        .frameError(frameError),
        .busy      (busy),
        .errorCount(errorCount)
    );

    always #5 clk = ~clk;

    // Pulse counters and overlap watch, sampled mid-cycle
    always @(negedge clk) begin
        if (wordValid === 1'b1) wv_pulses++;
        if (frameError === 1'b1) fe_pulses++;
        if (wordValid === 1'b1 && frameError === 1'b1) both_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step(input logic b, input logic v);
        bitIn    = b;
        bitValid = v;
        @(posedge clk);
        #1;
    endtask

    // Full frame, LSB first; optional stall (bitValid=0, bitIn=0) before each bit
    task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit, input bit stall);
        if (stall) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        for (int i = 0; i < DW; i++) begin
            if (stall) step(1'b0, 1'b0);
            step(d[i], 1'b1);
        end
`ifdef SHIFT_DESER_PARITY_EN
        if (stall) step(1'b0, 1'b0);
        step((^d) ^ par_flip, 1'b1);
`endif
        if (stall) step(1'b0, 1'b0);
        step(stop_bit, 1'b1);
    endtask

    initial begin
        // 1: reset held with live, toggling input
        rst = 1'b1;
        bitValid = 1'b1;
        bitIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bitIn = i[0];
            @(posedge clk);
            #1;
            chk("rst_wordOut", 32'(wordOut), 32'h00);
            chk("rst_wordValid", 32'(wordValid), 32'h0);
            chk("rst_frameError", 32'(frameError), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_errorCount", 32'(errorCount), 32'h0);
        end
        rst = 1'b0;
        step(1'b1, 1'b1);
        chk("idle_busy", 32'(busy), 32'h0);

        // 2: single frame 0x0F, bits 0,1,1,1,1,0,0,0,0,1
        wv0 = wv_pulses;
        step(1'b0, 1'b1);
        chk("t2_busy_after_start", 32'(busy), 32'h1);
        for (int i = 0; i < DW; i++) begin
            step((i < 4) ? 1'b1 : 1'b0, 1'b1);
            chk("t2_no_early_wv", 32'(wordValid), 32'h0);
        end
`ifdef SHIFT_DESER_PARITY_EN
        step(1'b0, 1'b1);
`endif
        step(1'b1, 1'b1);
        chk("t2_wordValid", 32'(wordValid), 32'h1);
        chk("t2_wordOut", 32'(wordOut), 32'h0F);
        chk("t2_busy_done", 32'(busy), 32'h0);
        step(1'b1, 1'b1);
        chk("t2_wv_drop", 32'(wordValid), 32'h0);
        chk("t2_wordOut_hold", 32'(wordOut), 32'h0F);
        chk("t2_pulses", 32'(wv_pulses - wv0), 32'd1);

        // 3: same frame with stalls between every bit
        wv0 = wv_pulses;
        send_frame(8'h0F, 1'b1, 1'b1);
        chk("t3_wordValid", 32'(wordValid), 32'h1);
        chk("t3_wordOut", 32'(wordOut), 32'h0F);
        step(1'b0, 1'b0);
        chk("t3_wv_drop_on_stall", 32'(wordValid), 32'h0);
        chk("t3_stall_no_start", 32'(busy), 32'h0);
        step(1'b1, 1'b1);
        chk("t3_pulses", 32'(wv_pulses - wv0), 32'd1);

        // 4: framing error, data 0xA5 with stop bit 0
        wv0 = wv_pulses;
        fe0 = fe_pulses;
        send_frame(8'hA5, 1'b0, 1'b0);
        chk("t4_frameError", 32'(frameError), 32'h1);
        chk("t4_no_wv", 32'(wordValid), 32'h0);
        chk("t4_errorCount", 32'(errorCount), 32'd1);
        chk("t4_wordOut_hold", 32'(wordOut), 32'h0F);
        chk("t4_stop0_not_start", 32'(busy), 32'h0);
        step(1'b1, 1'b1);
        chk("t4_fe_drop", 32'(frameError), 32'h0);
        chk("t4_fe_pulses", 32'(fe_pulses - fe0), 32'd1);
        chk("t4_wv_pulses", 32'(wv_pulses - wv0), 32'd0);

        // 5: back-to-back 0x3C then 0xC3, start bit taken during the pulse
        wv0 = wv_pulses;
        send_frame(8'h3C, 1'b1, 1'b0);
        chk("t5_wv_first", 32'(wordValid), 32'h1);
        chk("t5_word_first", 32'(wordOut), 32'h3C);
        send_frame(8'hC3, 1'b1, 1'b0);
        chk("t5_wv_second", 32'(wordValid), 32'h1);
        chk("t5_word_second", 32'(wordOut), 32'hC3);
        step(1'b1, 1'b1);
        chk("t5_pulses", 32'(wv_pulses - wv0), 32'd2);

        // 6: reset after 4 data bits, then a clean 0x55 frame
        wv0 = wv_pulses;
        fe0 = fe_pulses;
        step(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        rst = 1'b1;
        step(1'b1, 1'b1);
        rst = 1'b0;
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_wordOut", 32'(wordOut), 32'h00);
        chk("t6_rst_errorCount", 32'(errorCount), 32'h0);
`ifdef SHIFT_DESER_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h55, 1'b1, 1'b0);
        par_flip = 1'b0;
        chk("t6_par_frameError", 32'(frameError), 32'h1);
        chk("t6_par_no_wv", 32'(wordValid), 32'h0);
        chk("t6_par_wordOut", 32'(wordOut), 32'h00);
        chk("t6_par_errorCount", 32'(errorCount), 32'd1);
        step(1'b1, 1'b1);
        chk("t6_wv_pulses", 32'(wv_pulses - wv0), 32'd0);
        chk("t6_fe_pulses", 32'(fe_pulses - fe0), 32'd1);
        base = 1;
`else
        send_frame(8'h55, 1'b1, 1'b0);
        chk("t6_wordValid", 32'(wordValid), 32'h1);
        chk("t6_wordOut", 32'(wordOut), 32'h55);
        step(1'b1, 1'b1);
        chk("t6_wv_pulses", 32'(wv_pulses - wv0), 32'd1);
        chk("t6_fe_pulses", 32'(fe_pulses - fe0), 32'd0);
        base = 0;
`endif

        // 7: error counter saturates at all-ones and never wraps
        for (int i = base; i < 255; i++) send_frame(8'h00, 1'b0, 1'b0);
        chk("t7_at_max", 32'(errorCount), 32'd255);
        for (int i = 0; i < 5; i++) send_frame(8'h00, 1'b0, 1'b0);
        chk("t7_fe_still_pulses", 32'(frameError), 32'h1);
        chk("t7_saturated", 32'(errorCount), 32'd255);
        step(1'b1, 1'b1);

        chk("no_wv_fe_overlap", 32'(both_seen), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
